// File: rtl/pwm_multichannel.sv
// -----------------------------------------------------------------------------
// pwm_multichannel
//   Multi-channel PWM generator. A single shared counter runs in edge-aligned
//   (0..P, wrap) or center-aligned (0..P..1, bounce) mode. Every channel
//   compares the counter against its own duty value. Period, duties and mode
//   are double-buffered: configuration writes land in shadow registers and are
//   copied to the active set only at the end of a period, or continuously
//   while the block is disabled.
//
//   Optional feature macro: PWM_POLARITY_EN
//     When defined, adds input 'pol'; pwm_out[i] is inverted when pol[i]=1,
//     including while disabled and in reset.
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous active-high reset (priority over cfg_we and en)
//   en           run enable; low parks the counter at 0 and loads shadows
//   mode         0 = edge-aligned, 1 = center-aligned (sampled at period end)
//   cfg_we       configuration write strobe
//   cfg_addr     0 = period, 1..NCH = duty of channel addr-1, others ignored
//   cfg_data     configuration write data
//   pol          (PWM_POLARITY_EN only) per-channel output inversion
//   pwm_out      registered PWM outputs
//   period_tick  registered one-cycle pulse marking the first sample of a period
// -----------------------------------------------------------------------------
module pwm_multichannel #(
  parameter int unsigned NCH   = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             mode,
  input  logic             cfg_we,
  input  logic [3:0]       cfg_addr,
  input  logic [WIDTH-1:0] cfg_data,
`ifdef PWM_POLARITY_EN
  input  logic [NCH-1:0]   pol,
`endif
  output logic [NCH-1:0]   pwm_out,
  output logic             period_tick
);

  localparam int unsigned AW = 4;

  // Shadow (software-visible) configuration
  logic [WIDTH-1:0] r_sh_per;
  logic [WIDTH-1:0] r_sh_duty [NCH];

  // Active configuration, only these drive the outputs
  logic [WIDTH-1:0] r_per;
  logic [WIDTH-1:0] r_duty [NCH];
  logic             r_mode;

  // Counter state; r_dir is the direction of the next step (1 = down)
  logic [WIDTH-1:0] r_cnt;
  logic             r_dir;

  // Output registers
  logic [NCH-1:0]   r_pwm;
  logic             r_tick;

  logic [WIDTH-1:0] w_cnt_nxt;
  logic             w_dir_nxt;
  logic             w_eop;
  logic             w_load;
  logic [NCH-1:0]   w_pwm_raw;
  logic [NCH-1:0]   w_pol;

`ifdef PWM_POLARITY_EN
  assign w_pol = pol;
`else
  assign w_pol = '0;
`endif

  // End-of-period detection and next counter value
  always_comb begin
    w_eop     = 1'b0;
    w_cnt_nxt = r_cnt;
    w_dir_nxt = r_dir;

    if (r_per == '0) begin
      // Degenerate period: every cycle closes a period, counter stays at 0
      w_eop = 1'b1;
    end else if (!r_mode) begin
      w_eop = (r_cnt == r_per);
    end else begin
      w_eop = r_dir && (r_cnt == WIDTH'(1));
    end

    if (!en || w_eop) begin
      w_cnt_nxt = '0;
      w_dir_nxt = 1'b0;
    end else if (!r_mode) begin
      w_cnt_nxt = r_cnt + WIDTH'(1);
      w_dir_nxt = 1'b0;
    end else if (!r_dir) begin
      // Rising half: turn around on the step that reaches P
      w_cnt_nxt = r_cnt + WIDTH'(1);
      w_dir_nxt = ((r_cnt + WIDTH'(1)) == r_per);
    end else begin
      // Falling half: stops at 1, the wrap to 0 is handled by w_eop
      w_cnt_nxt = r_cnt - WIDTH'(1);
      w_dir_nxt = 1'b1;
    end
  end

  // Active set is refreshed at period end and continuously while disabled
  assign w_load = !en || w_eop;

  // Per-channel compare against the current count
  always_comb begin
    w_pwm_raw = '0;
    for (int i = 0; i < NCH; i++) begin
      w_pwm_raw[i] = (r_cnt < r_duty[i]);
    end
  end

  // Configuration shadows, active set, counter and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sh_per <= '1;
      r_per    <= '1;
      r_mode   <= 1'b0;
      r_cnt    <= '0;
      r_dir    <= 1'b0;
      r_pwm    <= w_pol;
      r_tick   <= 1'b0;
      for (int i = 0; i < NCH; i++) begin
        r_sh_duty[i] <= '0;
        r_duty[i]    <= '0;
      end
    end else begin
      if (cfg_we && (cfg_addr == '0)) begin
        r_sh_per <= cfg_data;
      end
      for (int i = 0; i < NCH; i++) begin
        if (cfg_we && (cfg_addr == AW'(i + 1))) begin
          r_sh_duty[i] <= cfg_data;
        end
      end

      // Active values take the pre-write shadow when a write hits this edge
      if (w_load) begin
        r_per  <= r_sh_per;
        r_mode <= mode;
        for (int i = 0; i < NCH; i++) begin
          r_duty[i] <= r_sh_duty[i];
        end
      end

      r_cnt <= w_cnt_nxt;
      r_dir <= w_dir_nxt;

      if (en) begin
        r_pwm  <= w_pwm_raw ^ w_pol;
        // cnt==0 while enabled only ever occurs at a period start, so the
        // tick lines up with the pwm sample taken for cnt==0
        r_tick <= (r_cnt == '0);
      end else begin
        r_pwm  <= w_pol;
        r_tick <= 1'b0;
      end
    end
  end

  assign pwm_out     = r_pwm;
  assign period_tick = r_tick;

endmodule
